// File: rtl/ultrasonic_scan_scheduler.sv
// Round-robin HC-SR04 scan sequencer: fires one ranger at a time and keeps a per-sensor cm table.
// Optional proximity flags (near_thresh_i / near_alarm_o) are built when ULTRASONIC_NEAR_ALARM_EN is defined.
//
// state    | meaning
// S_IDLE   | scan stopped, waiting for enable
// S_TRIG   | trigger pin of current sensor high for TRIG_US
// S_WAIT   | waiting for a true 0->1 echo edge, bounded by TIMEOUT_US
// S_MEAS   | echo high, counting cm, bounded by TIMEOUT_US
// S_RESULT | single clock: table written, result_valid high
// S_GUARD  | acoustic quiet gap before the next sensor
module ultrasonic_scan_scheduler #(
   parameter int NUM_SENSORS  = 4,
   parameter int CLK_FREQ_MHZ = 100,
   parameter int TRIG_US      = 10,
   parameter int TIMEOUT_US   = 25000,
   parameter int GUARD_US     = 10000
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      enable_i,
   input  logic [NUM_SENSORS-1:0]    echo_i,
`ifdef ULTRASONIC_NEAR_ALARM_EN
   input  logic [15:0]               near_thresh_i,
   output logic [NUM_SENSORS-1:0]    near_alarm_o,
`endif
   output logic [NUM_SENSORS-1:0]    trigger_o,
   output logic [16*NUM_SENSORS-1:0] distance_o,
   output logic                      result_valid_o,
   output logic [2:0]                result_id_o,
   output logic                      timeout_err_o
);

   localparam int PRE_W   = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
   localparam int TMR_MAX = (TIMEOUT_US > GUARD_US) ?
                            ((TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US) :
                            ((GUARD_US > TRIG_US) ? GUARD_US : TRIG_US);
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(CLK_FREQ_MHZ - 1);
   localparam logic [TMR_W-1:0] TRIG_LD    = TMR_W'(TRIG_US - 1);
   localparam logic [TMR_W-1:0] TMO_LD     = TMR_W'(TIMEOUT_US - 1);
   localparam logic [TMR_W-1:0] GUARD_LD   = TMR_W'(GUARD_US - 1);
   localparam logic [5:0]       SUB_LD     = 6'd57;
   localparam logic [15:0]      CM_SAT     = 16'hFFFE;
   localparam logic [2:0]       IDX_LAST   = 3'(NUM_SENSORS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_TRIG, S_WAIT, S_MEAS, S_RESULT, S_GUARD
   } state_t;

   state_t                   state_q, state_d;
   logic [PRE_W-1:0]         presc_q;
   logic                     us_tick;
   logic [NUM_SENSORS-1:0]   echo_s1_q, echo_s2_q;
   logic                     echo_prev_q, echo_sel, echo_rise, echo_fall;
   logic [TMR_W-1:0]         tmr_q;
   logic                     tmr_tc;
   logic [5:0]               sub_q;
   logic [15:0]              cm_q;
   logic [2:0]               idx_q;
   logic                     tmo_d, tmo_q;
   logic                     res_wr;
   logic [2:0]               res_id_q;
   logic [16*NUM_SENSORS-1:0] dist_q;

   assign us_tick = (presc_q == '0);
   assign tmr_tc  = us_tick && (tmr_q == '0);

   always_comb begin
      echo_sel = 1'b0;
      for (int i = 0; i < NUM_SENSORS; i++)
         if (idx_q == 3'(i)) echo_sel = echo_s2_q[i];
   end

   assign echo_rise = echo_sel & ~echo_prev_q;
   assign echo_fall = ~echo_sel & echo_prev_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         presc_q     <= '0;
         echo_s1_q   <= '0;
         echo_s2_q   <= '0;
         echo_prev_q <= 1'b0;
      end else begin
         presc_q     <= us_tick ? PRE_RELOAD : presc_q - PRE_W'(1);
         echo_s1_q   <= echo_i;
         echo_s2_q   <= echo_s1_q;
         echo_prev_q <= echo_sel;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      tmo_d   = 1'b0;
      case (state_q)
         S_IDLE:   if (enable_i) state_d = S_TRIG;
         S_TRIG:   if (tmr_tc) state_d = S_WAIT;
         S_WAIT: begin
            if (echo_rise) state_d = S_MEAS;
            else if (tmr_tc) begin
               state_d = S_RESULT;
               tmo_d   = 1'b1;
            end
         end
         S_MEAS: begin
            if (echo_fall) state_d = S_RESULT;
            else if (tmr_tc) begin
               state_d = S_RESULT;
               tmo_d   = 1'b1;
            end
         end
         S_RESULT: state_d = S_GUARD;
         S_GUARD:  if (tmr_tc) state_d = enable_i ? S_TRIG : S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      trigger_o      = '0;
      result_valid_o = 1'b0;
      timeout_err_o  = 1'b0;
      for (int i = 0; i < NUM_SENSORS; i++)
         if (state_q == S_TRIG && idx_q == 3'(i)) trigger_o[i] = 1'b1;
      if (state_q == S_RESULT) begin
         result_valid_o = 1'b1;
         timeout_err_o  = tmo_q;
      end
   end

   assign res_wr = (state_d == S_RESULT) && (state_q != S_RESULT);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tmr_q    <= '0;
         sub_q    <= '0;
         cm_q     <= '0;
         idx_q    <= '0;
         tmo_q    <= 1'b0;
         res_id_q <= '0;
         dist_q   <= '0;
      end else begin
         // timer reloads on every state change, so each state times from its own entry
         if (state_d != state_q) begin
            case (state_d)
               S_TRIG:         tmr_q <= TRIG_LD;
               S_WAIT, S_MEAS: tmr_q <= TMO_LD;
               S_GUARD:        tmr_q <= GUARD_LD;
               default:        tmr_q <= tmr_q;
            endcase
         end else if (us_tick && tmr_q != '0) begin
            tmr_q <= tmr_q - TMR_W'(1);
         end

         // 58 us per cm without a divider
         if (state_q != S_MEAS) begin
            sub_q <= SUB_LD;
            cm_q  <= '0;
         end else if (us_tick) begin
            if (sub_q == '0) begin
               sub_q <= SUB_LD;
               if (cm_q != CM_SAT) cm_q <= cm_q + 16'd1;
            end else begin
               sub_q <= sub_q - 6'd1;
            end
         end

         if (res_wr) begin
            tmo_q    <= tmo_d;
            res_id_q <= idx_q;
            for (int i = 0; i < NUM_SENSORS; i++)
               if (idx_q == 3'(i)) dist_q[16*i +: 16] <= tmo_d ? 16'hFFFF : cm_q;
         end

         if (state_q == S_GUARD && state_d != S_GUARD)
            idx_q <= (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
      end
   end

   assign distance_o  = dist_q;
   assign result_id_o = res_id_q;

`ifdef ULTRASONIC_NEAR_ALARM_EN
   logic [NUM_SENSORS-1:0] near_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         near_q <= '0;
      end else if (res_wr) begin
         for (int i = 0; i < NUM_SENSORS; i++)
            if (idx_q == 3'(i)) near_q[i] <= !tmo_d && (cm_q < near_thresh_i);
      end
   end

   assign near_alarm_o = near_q;
`endif

endmodule

// File: tb/tb_ultrasonic_scan_scheduler.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops and compares them.
module tb_ultrasonic_scan_scheduler;
   localparam int N     = 4;
   localparam int F     = 2;
   localparam int TRIG  = 10;
   localparam int TMO   = 600;
   localparam int GUARD = 50;

   localparam int M_ECHO   = 0;
   localparam int M_NOECHO = 1;
   localparam int M_LONG   = 2;
   localparam int M_PRE    = 3;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               enable = 1'b0;
   logic [N-1:0]       echo = '0;
   logic [N-1:0]       trigger_o;
   logic [16*N-1:0]    distance_o;
   logic               result_valid_o;
   logic [2:0]         result_id_o;
   logic               timeout_err_o;
`ifdef ULTRASONIC_NEAR_ALARM_EN
   logic [15:0]        near_thresh = 16'd3;
   logic [N-1:0]       near_alarm_o;
   logic [N-1:0]       mna = '0;
`endif

   ultrasonic_scan_scheduler #(
      .NUM_SENSORS(N), .CLK_FREQ_MHZ(F), .TRIG_US(TRIG), .TIMEOUT_US(TMO), .GUARD_US(GUARD)
   ) dut (
      .clk_i(clk),
      .rst_n_i(rst_n),
      .enable_i(enable),
      .echo_i(echo),
`ifdef ULTRASONIC_NEAR_ALARM_EN
      .near_thresh_i(near_thresh),
      .near_alarm_o(near_alarm_o),
`endif
      .trigger_o(trigger_o),
      .distance_o(distance_o),
      .result_valid_o(result_valid_o),
      .result_id_o(result_id_o),
      .timeout_err_o(timeout_err_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          id;
      logic [15:0] val;
      bit          tmo;
      int          lo;
      int          hi;
   } exp_t;

   exp_t           expq[$];
   logic [16*N-1:0] mdl = '0;
   int n_cmp = 0;
   int n_err = 0;
   int last_rv = -1;
   int exp_idx = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
      n_cmp++;
      if (act < lo || act > hi) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", nm, act, lo, hi, cyc);
      end
   endtask

   task automatic push(input int id, input logic [15:0] v, input bit t, input int lo, input int hi);
      exp_t x;
      x.id = id; x.val = v; x.tmo = t; x.lo = lo; x.hi = hi;
      expq.push_back(x);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (trigger_o != '0) chk("trigger_onehot", 64'($countones(trigger_o)), 64'd1);
         if (result_valid_o) begin
            last_rv = cyc;
            if (expq.size() == 0) begin
               chk("unexpected_result", 64'(expq.size()), 64'd1);
            end else begin
               e = expq.pop_front();
               chk("result_id", 64'(result_id_o), 64'(e.id));
               chk("timeout_err", 64'(timeout_err_o), 64'(e.tmo));
               chk("entry_value", 64'(distance_o[16*e.id +: 16]), 64'(e.val));
               chk_rng("result_cycle", cyc, e.lo, e.hi);
               mdl[16*e.id +: 16] = e.val;
               chk("table", 64'(distance_o), 64'(mdl));
`ifdef ULTRASONIC_NEAR_ALARM_EN
               mna[e.id] = !e.tmo && (e.val < near_thresh);
               chk("near_alarm", 64'(near_alarm_o), 64'(mna));
`endif
            end
         end
      end
   end

   task automatic add_noise(input int s);
      logic [31:0]  rnd;
      logic [N-1:0] msk;
      rnd = $urandom;
      msk = '0;
      msk[s] = 1'b1;
      echo = (echo & msk) | (rnd[N-1:0] & ~msk);
   endtask

   task automatic wait_trig(output int s, output bit ok);
      int w = 0;
      while (trigger_o == '0 && w < 600) begin
         step();
         w++;
      end
      ok = (trigger_o != '0);
      chk("trigger_seen", 64'(ok), 64'd1);
      s = 0;
      for (int i = 0; i < N; i++) if (trigger_o[i]) s = i;
   endtask

   task automatic drain();
      int w = 0;
      while (expq.size() != 0 && w < TMO * F + 200) begin
         step();
         w++;
      end
      if (expq.size() != 0) begin
         chk("result_missing", 64'(expq.size()), 64'd0);
         expq.delete();
      end
   endtask

   task automatic run_slot(input int mode, input int kf, input bit drop);
      int s, tr, tf, r, f, d, k, e, w;
      bit ok;
      wait_trig(s, ok);
      if (!ok) return;
      tr = cyc;
      chk("trigger_order", 64'(s), 64'(exp_idx));
      exp_idx = (exp_idx + 1) % N;
      if (last_rv >= 0) chk_rng("guard_gap", tr - last_rv, (GUARD - 1) * F + 2, GUARD * F + 1);
      add_noise(s);
      if (mode == M_PRE) echo[s] = 1'b1;
      w = 0;
      while (trigger_o != '0 && w < 100) begin
         step();
         w++;
      end
      tf = cyc;
      chk_rng("trigger_width", tf - tr, (TRIG - 1) * F + 1, TRIG * F);
      d = $urandom_range(5, 100);
      k = (kf >= 0) ? kf : $urandom_range(0, 6);
      e = 58 * k + 29;
      case (mode)
         M_NOECHO: push(s, 16'hFFFF, 1'b1, tf + (TMO - 1) * F + 1, tf + TMO * F);
         M_LONG: begin
            repeat (d * F) step();
            echo[s] = 1'b1;
            r = cyc;
            push(s, 16'hFFFF, 1'b1, r + 3 + (TMO - 1) * F + 1, r + 3 + TMO * F);
            repeat ((TMO + 20) * F) step();
            echo[s] = 1'b0;
         end
         default: begin
            if (mode == M_PRE) begin
               repeat (20 * F) step();
               echo[s] = 1'b0;
            end
            repeat (d * F) step();
            echo[s] = 1'b1;
            add_noise(s);
            if (drop) enable = 1'b0;
            repeat (e * F) step();
            echo[s] = 1'b0;
            f = cyc;
            push(s, 16'(k), 1'b0, f + 3, f + 3);
         end
      endcase
      drain();
      echo = '0;
   endtask

   initial begin
      int mode, kf, s, seen;
      bit ok;
      repeat (3) step();
      chk("rst_trigger", 64'(trigger_o), 64'd0);
      chk("rst_distance", 64'(distance_o), 64'd0);
      chk("rst_valid", 64'(result_valid_o), 64'd0);
      chk("rst_id", 64'(result_id_o), 64'd0);
      chk("rst_timeout", 64'(timeout_err_o), 64'd0);
      rst_n = 1'b1;
      repeat (30) step();
      chk("idle_disabled", 64'(trigger_o), 64'd0);
      enable = 1'b1;

      for (int i = 0; i < 20; i++) begin
         case (i)
            0: begin mode = M_ECHO;   kf = 1;  end
            1: begin mode = M_NOECHO; kf = -1; end
            2: begin mode = M_LONG;   kf = -1; end
            3: begin mode = M_PRE;    kf = -1; end
            4: begin mode = M_ECHO;   kf = 0;  end
            5: begin mode = M_ECHO;   kf = 6;  end
            default: begin
               kf = -1;
               case ($urandom_range(0, 9))
                  0, 1, 2, 3, 4, 5: mode = M_ECHO;
                  6:                mode = M_NOECHO;
                  7:                mode = M_LONG;
                  default:          mode = M_PRE;
               endcase
            end
         endcase
         if (i == 9) mode = M_ECHO;
         run_slot(mode, kf, i == 9);
         if (i == 9) begin
            seen = 0;
            repeat (400) begin
               step();
               if (trigger_o != '0) seen++;
            end
            chk("idle_after_disable", 64'(seen), 64'd0);
            enable = 1'b1;
            last_rv = -1;
         end
      end

      // async reset in the middle of a trigger pulse
      wait_trig(s, ok);
      repeat (4) step();
      chk("trig_before_rst", 64'(trigger_o != '0), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_trigger", 64'(trigger_o), 64'd0);
      chk("rst_async_table", 64'(distance_o), 64'd0);
      chk("rst_async_valid", 64'(result_valid_o), 64'd0);
      mdl = '0;
`ifdef ULTRASONIC_NEAR_ALARM_EN
      mna = '0;
`endif
      exp_idx = 0;
      last_rv = -1;
      expq.delete();
      echo = '0;
      step();
      step();
      rst_n = 1'b1;
      run_slot(M_ECHO, 2, 1'b0);
      run_slot(M_ECHO, -1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #900000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
